traffic_phase_ctrl: RTL
=======================

Name: traffic_phase_ctrl

Overview:
Parametrised successor of the intersection traffic-light FSM. Sequences N_CH approaches through green/amber phases, each phase timed in ticks. Per-phase durations come from a writable timing table. The table is selected per cycle from vehicle sensors, and pedestrian requests shorten the current green. It sits between the sensor/pushbutton inputs and the lamp drivers.

Parameters:
N_CH, 3, number of approaches (Norton N, Norton S, TH); legal range 2..7
TIME_W, 8, width of phase durations in ticks
TICK_DIV, 48000000, CLK cycles per tick (1 s at 48 MHz)
DEF_TIME, 17, reset value of every timing-table entry
GREEN_MIN, 5, green clip value in ticks when a pedestrian request is pending

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
SENS  in  N_CH  vehicle sensors, bit i = approach i
PB  in  N_CH  pedestrian pushbuttons, bit i = approach i
CFG_WE  in  1  timing-table write strobe
CFG_TBL  in  TW  table index; TW = $clog2(N_CH+1)
CFG_PHASE  in  PW  phase index; PW = $clog2(2*N_CH)
CFG_DATA  in  TIME_W  duration in ticks
GRN  out  N_CH  green lamps
AMB  out  N_CH  amber lamps
RED  out  N_CH  red lamps, equal to ~(GRN|AMB)
CS  out  N_CH  one-cycle pulse when approach i changes colour
PHASE  out  PW  current phase
TABLE  out  TW  current timing table
REQ  out  N_CH  latched pedestrian requests

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST). All state updates on CLK rising edge.
- Phases: 2*N_CH in total. Phase 2i is GREEN_i (GRN[i]=1). Phase 2i+1 is AMBER_i (AMB[i]=1). Phase 2*N_CH-1 advances to 0.
- Outputs: at most one bit of GRN|AMB is set. All outputs are registered.
- Reset: PHASE=0, TABLE=0, GRN=1 (bit 0 only), AMB=0, RED=~1, CS=0, REQ=0. Prescaler=0. Timer=DEF_TIME. Every table entry = DEF_TIME. CFG_WE is ignored while RST=1.
- Tick prescaler:
  - Counts 0..TICK_DIV-1 and emits a tick when the count equals TICK_DIV-1.
  - It restarts at 0 in every phase-entry cycle, so a phase of duration D lasts exactly D*TICK_DIV cycles.
- Timer:
  - Loaded with the table entry at phase entry.
  - A loaded value of 0 is treated as 1.
  - On tick: if timer<=1, advance phase; otherwise timer-1.
- Table selection:
  - Evaluated in the cycle a GREEN phase is entered, from SENS sampled that cycle.
  - Exactly one SENS bit k set gives TABLE=k+1. Zero or multiple bits set gives TABLE=0.
  - The following AMBER phase keeps the table. SENS changes mid-phase have no effect.
- Timing table:
  - (N_CH+1) x 2*N_CH entries of TIME_W bits.
  - CFG_WE writes CFG_DATA to [CFG_TBL][CFG_PHASE].
  - Out-of-range indices are ignored.
  - A write affects only later phase loads. A write to the entry being loaded in the same cycle returns the old value.
- Pedestrian requests:
  - PB[j]=1 sets REQ[j].
  - REQ[j] is cleared in the cycle GREEN_j is entered. Clear wins over a simultaneous set.
  - While in GREEN_i with REQ&~(1<<i) nonzero and timer>GREEN_MIN, the timer is set to GREEN_MIN next cycle. Amber phases are never shortened.
- CS pulses:
  - GREEN_i->AMBER_i pulses CS[i].
  - AMBER_i->GREEN_(i+1 mod N_CH) pulses CS[i] and CS[next].
  - The pulse is asserted in the same cycle as the lamp change.
- Reset mid-phase: immediate return to reset state on the next edge, with no CS pulse.

Optional Feature:
INPUT_SYNC_EN
- Defined: SENS and PB each pass through a 2-flop synchronizer. Sensor and button effects lag by 2 cycles.
- Undefined: inputs are used directly and must be synchronous to CLK.

Test Plan:
Use N_CH=3, TICK_DIV=4, DEF_TIME=3, GREEN_MIN=1 unless stated.
1. Reset then idle -> PHASE steps 0..5 every 12 cycles, then wraps to 0. CS[0] pulses at cycle 12. CS[0] and CS[1] pulse at cycle 24.
2. Write tbl0/phase0 = 5, then enter phase 0 -> GREEN_0 lasts 20 cycles. Write tbl0/phase2 = 0 -> GREEN_1 lasts 4 cycles.
3. SENS=010 held at GREEN_1 entry -> TABLE=2, and the tbl2 durations apply to GREEN_1/AMBER_1. SENS=011 -> TABLE=0. A SENS change mid-green leaves TABLE unchanged.
4. With tbl0/phase0=10, pulse PB[2] 8 cycles into GREEN_0 -> REQ=100 and the timer is clipped to 1. GREEN_0 ends within 4 cycles and REQ[2] clears at GREEN_2 entry.
5. PB[1] held during the GREEN_1 entry cycle -> REQ[1]=0 that cycle and reasserts next cycle.
6. RST asserted mid AMBER_1 -> next edge shows PHASE=0, GRN=001, REQ=0, CS=0, and the table reverts to DEF_TIME.

Source files
------------

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: sequences N_CH approaches through GREEN_i / AMBER_i phases.
// Each phase runs for a number of ticks taken from a writable timing table.
// The table is chosen from the vehicle sensors at each green entry.
// Latched pedestrian requests clip the current green down to GREEN_MIN ticks.
// Optional macro INPUT_SYNC_EN: when defined, SENS and PB each pass through a
// 2-flop synchronizer, so their effects lag by two cycles.
module traffic_phase_ctrl #(
  parameter int N_CH      = 3,
  parameter int TIME_W    = 8,
  parameter int TICK_DIV  = 48000000,
  parameter int DEF_TIME  = 17,
  parameter int GREEN_MIN = 5,
  localparam int TW       = $clog2(N_CH + 1),
  localparam int PW       = $clog2(2 * N_CH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_CH-1:0]   SENS,
  input  logic [N_CH-1:0]   PB,
  input  logic              CFG_WE,
  input  logic [TW-1:0]     CFG_TBL,
  input  logic [PW-1:0]     CFG_PHASE,
  input  logic [TIME_W-1:0] CFG_DATA,
  output logic [N_CH-1:0]   GRN,
  output logic [N_CH-1:0]   AMB,
  output logic [N_CH-1:0]   RED,
  output logic [N_CH-1:0]   CS,
  output logic [PW-1:0]     PHASE,
  output logic [TW-1:0]     TABLE,
  output logic [N_CH-1:0]   REQ
);

  // The phase index is {approach, colour}, so PHASE = 2*approach + colour.
  localparam int CW    = PW - 1;
  localparam int NT    = N_CH + 1;
  localparam int NP    = 2 * N_CH;
  localparam int PSC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [0:0] {
    ST_GREEN = 1'b0,
    ST_AMBER = 1'b1
  } color_t;

  color_t            color_r;
  color_t            color_nxt_s;
  logic [CW-1:0]     ch_r;
  logic [CW-1:0]     ch_nxt_s;
  logic [PSC_W-1:0]  psc_r;
  logic [PSC_W-1:0]  psc_nxt_s;
  logic [TIME_W-1:0] timer_r;
  logic [TIME_W-1:0] timer_nxt_s;
  logic [TW-1:0]     table_r;
  logic [TW-1:0]     table_nxt_s;
  logic [N_CH-1:0]   req_r;
  logic [N_CH-1:0]   req_nxt_s;
  logic [N_CH-1:0]   grn_r;
  logic [N_CH-1:0]   amb_r;
  logic [N_CH-1:0]   red_r;
  logic [N_CH-1:0]   cs_r;
  logic [N_CH-1:0]   grn_nxt_s;
  logic [N_CH-1:0]   amb_nxt_s;
  logic [N_CH-1:0]   cs_nxt_s;
  logic [TIME_W-1:0] tbl_r [NT][NP];

  logic [N_CH-1:0]   sens_s;
  logic [N_CH-1:0]   pb_s;
  logic [N_CH-1:0]   own_s;
  logic [TW-1:0]     sens_sel_s;
  logic [PW-1:0]     phase_nxt_s;
  logic [TIME_W-1:0] ld_raw_s;
  logic [TIME_W-1:0] ld_s;
  logic              tick_s;
  logic              advance_s;
  logic              enter_green_s;
  logic              clip_s;
  logic              cfg_ok_s;

`ifdef INPUT_SYNC_EN
  logic [N_CH-1:0] sens_meta_r;
  logic [N_CH-1:0] sens_sync_r;
  logic [N_CH-1:0] pb_meta_r;
  logic [N_CH-1:0] pb_sync_r;

  // two-flop synchronizers for the asynchronous sensor and button inputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      sens_meta_r <= {N_CH{1'b0}};
      sens_sync_r <= {N_CH{1'b0}};
      pb_meta_r   <= {N_CH{1'b0}};
      pb_sync_r   <= {N_CH{1'b0}};
    end else begin
      sens_meta_r <= SENS;
      sens_sync_r <= sens_meta_r;
      pb_meta_r   <= PB;
      pb_sync_r   <= pb_meta_r;
    end
  end

  assign sens_s = sens_sync_r;
  assign pb_s   = pb_sync_r;
`else
  assign sens_s = SENS;
  assign pb_s   = PB;
`endif

  // table choice from sensors: a single active sensor k selects table k+1
  always_comb begin
    sens_sel_s = {TW{1'b0}};
    for (int k = 0; k < N_CH; k++) begin
      if (sens_s == (N_CH'(1) << k)) begin
        sens_sel_s = TW'(k + 1);
      end else begin
        sens_sel_s = sens_sel_s;
      end
    end
  end

  // tick, phase-expiry, pedestrian clip and config-address qualification
  always_comb begin
    tick_s    = (psc_r == PSC_W'(TICK_DIV - 1));
    advance_s = tick_s && (timer_r <= TIME_W'(1));
    own_s     = N_CH'(1) << ch_r;
    clip_s    = (color_r == ST_GREEN) && ((req_r & ~own_s) != {N_CH{1'b0}}) &&
                (timer_r > TIME_W'(GREEN_MIN));
    cfg_ok_s  = CFG_WE && (int'(CFG_TBL) <= N_CH) && (int'(CFG_PHASE) < NP);
  end

  // phase FSM next state: GREEN_i -> AMBER_i -> GREEN_(i+1 mod N_CH)
  always_comb begin
    color_nxt_s = color_r;
    ch_nxt_s    = ch_r;
    if (advance_s) begin
      case (color_r)
        ST_GREEN: begin
          color_nxt_s = ST_AMBER;
          ch_nxt_s    = ch_r;
        end
        ST_AMBER: begin
          color_nxt_s = ST_GREEN;
          ch_nxt_s    = (ch_r == CW'(N_CH - 1)) ? {CW{1'b0}} : ch_r + CW'(1);
        end
        default: begin
          color_nxt_s = ST_GREEN;
          ch_nxt_s    = {CW{1'b0}};
        end
      endcase
    end else begin
      color_nxt_s = color_r;
      ch_nxt_s    = ch_r;
    end
    enter_green_s = advance_s && (color_nxt_s == ST_GREEN);
    phase_nxt_s   = {ch_nxt_s, color_nxt_s};
  end

  // timer, prescaler, table register and request latch next values
  always_comb begin
    table_nxt_s = enter_green_s ? sens_sel_s : table_r;
    // reads the pre-write table contents, so a same-cycle write is not seen
    ld_raw_s    = tbl_r[table_nxt_s][phase_nxt_s];
    ld_s        = (ld_raw_s == {TIME_W{1'b0}}) ? TIME_W'(1) : ld_raw_s;

    if (advance_s) begin
      timer_nxt_s = ld_s;
    end else if (clip_s) begin
      timer_nxt_s = TIME_W'(GREEN_MIN);
    end else if (tick_s) begin
      timer_nxt_s = timer_r - TIME_W'(1);
    end else begin
      timer_nxt_s = timer_r;
    end

    if (advance_s || tick_s) begin
      psc_nxt_s = {PSC_W{1'b0}};
    end else begin
      psc_nxt_s = psc_r + PSC_W'(1);
    end

    req_nxt_s = req_r | pb_s;
    if (enter_green_s) begin
      // the clear for the approach going green wins over a new press
      req_nxt_s = req_nxt_s & ~(N_CH'(1) << ch_nxt_s);
    end else begin
      req_nxt_s = req_nxt_s;
    end
  end

  // lamp and colour-change pulse values for the next cycle
  always_comb begin
    grn_nxt_s = {N_CH{1'b0}};
    amb_nxt_s = {N_CH{1'b0}};
    cs_nxt_s  = {N_CH{1'b0}};
    case (color_nxt_s)
      ST_GREEN: grn_nxt_s = N_CH'(1) << ch_nxt_s;
      ST_AMBER: amb_nxt_s = N_CH'(1) << ch_nxt_s;
      default:  grn_nxt_s = N_CH'(1);
    endcase
    if (advance_s) begin
      if (color_r == ST_GREEN) begin
        cs_nxt_s = own_s;
      end else begin
        cs_nxt_s = own_s | (N_CH'(1) << ch_nxt_s);
      end
    end else begin
      cs_nxt_s = {N_CH{1'b0}};
    end
  end

  // phase FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      color_r <= ST_GREEN;
      ch_r    <= {CW{1'b0}};
    end else begin
      color_r <= color_nxt_s;
      ch_r    <= ch_nxt_s;
    end
  end

  // timing state, request latch and registered lamp outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      psc_r   <= {PSC_W{1'b0}};
      timer_r <= TIME_W'(DEF_TIME);
      table_r <= {TW{1'b0}};
      req_r   <= {N_CH{1'b0}};
      grn_r   <= N_CH'(1);
      amb_r   <= {N_CH{1'b0}};
      red_r   <= ~N_CH'(1);
      cs_r    <= {N_CH{1'b0}};
    end else begin
      psc_r   <= psc_nxt_s;
      timer_r <= timer_nxt_s;
      table_r <= table_nxt_s;
      req_r   <= req_nxt_s;
      grn_r   <= grn_nxt_s;
      amb_r   <= amb_nxt_s;
      red_r   <= ~(grn_nxt_s | amb_nxt_s);
      cs_r    <= cs_nxt_s;
    end
  end

  // timing table storage; writes are held off during reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int t = 0; t < NT; t++) begin
        for (int p = 0; p < NP; p++) begin
          tbl_r[t][p] <= TIME_W'(DEF_TIME);
        end
      end
    end else if (cfg_ok_s) begin
      tbl_r[CFG_TBL][CFG_PHASE] <= CFG_DATA;
    end
  end

  assign PHASE = {ch_r, color_r};
  assign TABLE = table_r;
  assign GRN   = grn_r;
  assign AMB   = amb_r;
  assign RED   = red_r;
  assign CS    = cs_r;
  assign REQ   = req_r;

endmodule
